jtframe_pll_rstgen: RTL and testbench

- Sits directly downstream of the game PLL; consumes its asynchronous `locked` output in the game clock domain.
- Produces a stretched, synchronous-release game reset, plus two fractional clock enables: `cen` and `cen2` (double rate).
- Reset is released only after `locked` has been stable for a programmable hold period.
- Any loss of lock re-asserts reset immediately. Clock enables run only while the game is out of reset.

---
 rtl/jtframe_pll_rstgen_pkg.sv | 20 ++
 rtl/jtframe_pll_rstgen_if.sv | 31 +++
 rtl/jtframe_frac_cen.sv | 38 +++
 rtl/jtframe_pll_rstgen.sv | 118 +++++++++++
 tb/tb_jtframe_pll_rstgen.sv | 198 +++++++++++++++++++
 5 files changed

// File: rtl/jtframe_pll_rstgen_pkg.sv
// Shared definitions for the PLL-driven game reset generator.
// State encoding and parameter legality helper.
package jtframe_rstgen_pkg;

    localparam logic [1:0] ST_WAIT = 2'd0;
    localparam logic [1:0] ST_HOLD = 2'd1;
    localparam logic [1:0] ST_RUN  = 2'd2;

    typedef enum logic [1:0] {
        WAIT_LOCK = ST_WAIT,
        HOLD      = ST_HOLD,
        RUN       = ST_RUN
    } state_t;

    // cen needs a nonzero rate and cen2 (twice as fast) must not exceed clk
    function automatic bit cen_legal(input int n, input int m);
        return (n > 0) && (2 * n <= m);
    endfunction

endpackage

// File: rtl/jtframe_pll_rstgen_if.sv
// Game-side reset and clock-enable bundle of the reset generator.
// master = generator, slave = game core / host.
interface jtframe_pll_rstgen_if;
    logic locked;
    logic soft_rst;
    logic rst_game;
    logic rst_n_game;
    logic cen;
    logic cen2;
    logic run;

    modport master (
        input  locked,
        input  soft_rst,
        output rst_game,
        output rst_n_game,
        output cen,
        output cen2,
        output run
    );

    modport slave (
        output locked,
        output soft_rst,
        input  rst_game,
        input  rst_n_game,
        input  cen,
        input  cen2,
        input  run
    );
endinterface

// File: rtl/jtframe_frac_cen.sv
// Fractional clock enable: pulses STEP times every MOD clk cycles.
// Phase restarts from zero whenever en drops.
module jtframe_frac_cen #(
    parameter int STEP = 1,
    parameter int MOD  = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    output logic cen
);

    localparam int AW = $clog2(MOD) + 1;

    logic [AW-1:0] acc;
    logic [AW:0]   sum;

    // one extra bit so acc+STEP can never wrap
    assign sum = {1'b0, acc} + (AW+1)'(STEP);

    // accumulate while enabled, emit registered pulse on each wrap
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc <= '0;
            cen <= 1'b0;
        end else if (!en) begin
            acc <= '0;
            cen <= 1'b0;
        end else if (sum >= (AW+1)'(MOD)) begin
            acc <= AW'(sum - (AW+1)'(MOD));
            cen <= 1'b1;
        end else begin
            acc <= AW'(sum);
            cen <= 1'b0;
        end
    end

endmodule

// File: rtl/jtframe_pll_rstgen.sv
// Game reset generator fed by the PLL lock signal.
// Stretched synchronous-release reset plus cen/cen2 enables.
module jtframe_pll_rstgen
    import jtframe_rstgen_pkg::*;
#(
    parameter int HOLD_CYC = 1024,
    parameter int CEN_N    = 1,
    parameter int CEN_M    = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    jtframe_pll_rstgen_if.master  bus
);

    localparam int CW = $clog2(HOLD_CYC) + 1;

    // the hold spans HOLD_CYC+1 counting edges, so release lands
    // 2+HOLD_CYC+1 edges after locked is first sampled high
    localparam logic [CW-1:0] HOLD_END = CW'(HOLD_CYC);

    if (HOLD_CYC < 1) begin : g_bad_hold
        $error("HOLD_CYC must be at least 1");
    end

    if (!cen_legal(CEN_N, CEN_M)) begin : g_bad_cen
        $error("CEN_N/CEN_M must satisfy 0 < 2*CEN_N <= CEN_M");
    end

    logic [1:0]    lsync;
    logic          lock_s;
    state_t        st, st_nx;
    logic [CW-1:0] cnt, cnt_nx;
    logic          run_next;

    assign lock_s   = lsync[1];
    assign run_next = (st_nx == RUN);

    // two-flop synchroniser for the asynchronous PLL lock
    always_ff @(posedge clk or posedge rst) begin
        if (rst) lsync <= 2'b00;
        else     lsync <= {lsync[0], bus.locked};
    end

    // next state: lock loss beats everything, soft_rst restarts the hold
    always_comb begin
        st_nx  = st;
        cnt_nx = cnt;
        if (!lock_s) begin
            st_nx  = WAIT_LOCK;
            cnt_nx = '0;
        end else begin
            unique case (st)
                WAIT_LOCK: begin
                    st_nx  = HOLD;
                    cnt_nx = '0;
                end
                HOLD: begin
                    if (bus.soft_rst) begin
                        cnt_nx = '0;
                    end else if (cnt == HOLD_END) begin
                        st_nx  = RUN;
                        cnt_nx = '0;
                    end else begin
                        cnt_nx = cnt + 1'b1;
                    end
                end
                RUN: begin
                    if (bus.soft_rst) begin
                        st_nx  = HOLD;
                        cnt_nx = '0;
                    end
                end
                default: begin
                    st_nx  = WAIT_LOCK;
                    cnt_nx = '0;
                end
            endcase
        end
    end

    // state, hold counter and registered reset outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st             <= WAIT_LOCK;
            cnt            <= '0;
            bus.rst_game   <= 1'b1;
            bus.rst_n_game <= 1'b0;
            bus.run        <= 1'b0;
        end else begin
            st             <= st_nx;
            cnt            <= cnt_nx;
            bus.rst_game   <= !run_next;
            bus.rst_n_game <= run_next;
            bus.run        <= run_next;
        end
    end

    jtframe_frac_cen #(
        .STEP (CEN_N),
        .MOD  (CEN_M)
    ) u_cen (
        .clk (clk),
        .rst (rst),
        .en  (run_next),
        .cen (bus.cen)
    );

    jtframe_frac_cen #(
        .STEP (2 * CEN_N),
        .MOD  (CEN_M)
    ) u_cen2 (
        .clk (clk),
        .rst (rst),
        .en  (run_next),
        .cen (bus.cen2)
    );

endmodule

// File: tb/tb_jtframe_pll_rstgen.sv
// Directed bench for jtframe_pll_rstgen: reset stretch,
// lock loss, soft reset, async reset and cen/cen2 rates.
module tb_jtframe_pll_rstgen;

    logic clk      = 1'b0;
    logic rst      = 1'b1;
    logic locked   = 1'b0;
    logic soft_rst = 1'b0;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    jtframe_pll_rstgen_if ifa ();
    jtframe_pll_rstgen_if ifb ();

    assign ifa.locked   = locked;
    assign ifa.soft_rst = soft_rst;
    assign ifb.locked   = locked;
    assign ifb.soft_rst = soft_rst;

    jtframe_pll_rstgen #(
        .HOLD_CYC (16),
        .CEN_N    (1),
        .CEN_M    (8)
    ) u_a (
        .clk (clk),
        .rst (rst),
        .bus (ifa.master)
    );

    jtframe_pll_rstgen #(
        .HOLD_CYC (16),
        .CEN_N    (3),
        .CEN_M    (8)
    ) u_b (
        .clk (clk),
        .rst (rst),
        .bus (ifb.master)
    );

    task automatic chk(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_rst_game"}, int'(ifa.rst_game), 1);
        chk({tag, "_rst_n"}, int'(ifa.rst_n_game), 0);
        chk({tag, "_cen"}, int'(ifa.cen), 0);
        chk({tag, "_cen2"}, int'(ifa.cen2), 0);
        chk({tag, "_run"}, int'(ifa.run), 0);
    endtask

    // edge 0 is the next tick; expects release after edge 19
    task automatic chk_release(input string tag);
        int seen;
        seen = 0;
        for (int k = 0; k <= 19; k++) begin
            tick();
            chk($sformatf("%s_rst%0d", tag, k), int'(ifa.rst_game),
                (k < 19) ? 1 : 0);
            chk($sformatf("%s_run%0d", tag, k), int'(ifa.run),
                (k < 19) ? 0 : 1);
            if (k < 19) seen += int'(ifa.cen | ifa.cen2);
        end
        chk({tag, "_rst_n"}, int'(ifa.rst_n_game), 1);
        chk({tag, "_cen_hold"}, seen, 0);
    endtask

    initial begin
        int first_a, first_a2, bad_a, bad_b, mis;
        int cnt_a, cnt_a2, cnt_b, cnt_b2, run_b2, max_b2;
        int ea, ea2, eb, eb2;

        repeat (3) tick();
        chk_reset("por");

        rst = 1'b0;
        repeat (4) tick();
        chk("nolock", int'(ifa.rst_game), 1);

        locked = 1'b1;
        chk_release("lock");

        first_a = 0; first_a2 = 0; bad_a = 0; bad_b = 0; mis = 0;
        cnt_a = 0; cnt_a2 = 0; cnt_b = 0; cnt_b2 = 0;
        run_b2 = 0; max_b2 = 0;
        for (int c = 1; c <= 1000; c++) begin
            if (c > 1) tick();
            ea  = int'((c * 1) / 8 != ((c - 1) * 1) / 8);
            ea2 = int'((c * 2) / 8 != ((c - 1) * 2) / 8);
            eb  = int'((c * 3) / 8 != ((c - 1) * 3) / 8);
            eb2 = int'((c * 6) / 8 != ((c - 1) * 6) / 8);
            if (int'(ifa.cen) != ea || int'(ifa.cen2) != ea2) bad_a++;
            if (int'(ifb.cen) != eb || int'(ifb.cen2) != eb2) bad_b++;
            if ((ifa.cen && !ifa.cen2) || (ifb.cen && !ifb.cen2)) mis++;
            if (ifa.cen && first_a == 0) first_a = c;
            if (ifa.cen2 && first_a2 == 0) first_a2 = c;
            cnt_a  += int'(ifa.cen);
            cnt_a2 += int'(ifa.cen2);
            cnt_b  += int'(ifb.cen);
            cnt_b2 += int'(ifb.cen2);
            run_b2 = ifb.cen2 ? run_b2 + 1 : 0;
            if (run_b2 > max_b2) max_b2 = run_b2;
        end
        chk("first_cen", first_a, 8);
        chk("first_cen2", first_a2, 4);
        chk("pattern_1_8", bad_a, 0);
        chk("pattern_3_8", bad_b, 0);
        chk("cen_wo_cen2", mis, 0);
        chk("cnt_cen_1_8", cnt_a, 125);
        chk("cnt_cen2_1_8", cnt_a2, 250);
        chk("cnt_cen_3_8", cnt_b, 375);
        chk("cnt_cen2_3_8", cnt_b2, 750);
        chk("max_run_cen2", max_b2, 3);

        // one-cycle lock glitch in RUN
        locked = 1'b0;
        for (int k = 0; k <= 20; k++) begin
            tick();
            if (k == 0) locked = 1'b1;
            chk($sformatf("drop_rst%0d", k), int'(ifa.rst_game),
                (k >= 2 && k < 20) ? 1 : 0);
            if (k == 2) begin
                chk("drop_cen", int'(ifa.cen | ifb.cen), 0);
                chk("drop_cen2", int'(ifa.cen2 | ifb.cen2), 0);
                chk("drop_run", int'(ifa.run | ifb.run), 0);
            end
        end

        // soft reset in RUN, then restart mid-HOLD
        soft_rst = 1'b1;
        tick();
        soft_rst = 1'b0;
        chk("soft_run", int'(ifa.rst_game), 1);
        chk("soft_run_cen2", int'(ifb.cen2), 0);
        repeat (10) tick();
        chk("soft_hold", int'(ifa.rst_game), 1);
        soft_rst = 1'b1;
        tick();
        soft_rst = 1'b0;
        for (int j = 1; j <= 17; j++) begin
            tick();
            chk($sformatf("soft_rel%0d", j), int'(ifa.rst_game),
                (j < 17) ? 1 : 0);
        end

        // soft_rst coinciding with lock loss must go to WAIT_LOCK
        locked = 1'b0;
        tick();
        locked = 1'b1;
        tick();
        soft_rst = 1'b1;
        tick();
        soft_rst = 1'b0;
        chk("both_rst2", int'(ifa.rst_game), 1);
        for (int k = 3; k <= 20; k++) begin
            tick();
            chk($sformatf("both_rst%0d", k), int'(ifa.rst_game),
                (k < 20) ? 1 : 0);
        end

        // asynchronous reset while running
        #3;
        rst = 1'b1;
        #1;
        chk_reset("arst_run");
        #2;
        rst = 1'b0;
        for (int k = 0; k <= 5; k++) begin
            tick();
            chk($sformatf("arst_hold%0d", k), int'(ifa.rst_game), 1);
        end

        // asynchronous reset mid-HOLD, then a full hold again
        #3;
        rst = 1'b1;
        #1;
        chk_reset("arst_hold");
        #2;
        rst = 1'b0;
        chk_release("relock");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
